// File: rtl/pattern_player_if.sv
// Loader-side bus of pattern_player: valid/ready write handshake plus one
// pattern record (stimulus, expected response, compare mask).
interface pattern_player_if #(
  parameter int NINPUTS  = 5,
  parameter int NOUTPUTS = 2
);
  logic                load_valid;
  logic                load_ready;
  logic [NINPUTS-1:0]  load_pi;
  logic [NOUTPUTS-1:0] load_xpct;
  logic [NOUTPUTS-1:0] load_mask;

  // Pattern source (host or ROM) drives the record, player answers ready.
  modport master (output load_valid, load_pi, load_xpct, load_mask,
                  input  load_ready);
  modport slave  (input  load_valid, load_pi, load_xpct, load_mask,
                  output load_ready);
endinterface

// File: rtl/pattern_player.sv
// pattern_player: buffers {stimulus, expected, mask} records, applies them one
// at a time to a DUT, strobes the DUT outputs SETTLE cycles later and keeps
// pass/fail statistics for the run.
module pattern_player #(
  parameter int NINPUTS  = 5,
  parameter int NOUTPUTS = 2,
  parameter int DEPTH    = 16,
  parameter int SETTLE   = 2,
  parameter int CNTW     = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       clear,
  input  logic                       start,
  input  logic                       stop_on_fail,
  pattern_player_if.slave            ld,
  output logic [NINPUTS-1:0]         pi_out,
  input  logic [NOUTPUTS-1:0]        po_in,
  output logic                       busy,
  output logic                       done,
  output logic                       fail_pulse,
  output logic [$clog2(DEPTH)-1:0]   fail_pat,
  output logic [NOUTPUTS-1:0]        fail_bits,
  output logic [CNTW-1:0]            fail_count,
  output logic                       first_fail_valid,
  output logic [$clog2(DEPTH)-1:0]   first_fail_pat,
  output logic [$clog2(DEPTH):0]     pat_count
);
  localparam int AW = $clog2(DEPTH);
  // Wait counter needs at least one bit even when SETTLE is 0.
  localparam int WW = (SETTLE > 0) ? $clog2(SETTLE + 1) : 1;
  localparam logic [WW-1:0] WAIT_INIT = WW'(SETTLE);
  localparam logic [AW:0]   FULL      = (AW+1)'(DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  // Pattern buffer (no reset needed: occupancy is tracked by r_wr_ptr)
  logic [NINPUTS-1:0]  r_mem_pi [DEPTH];
  logic [NOUTPUTS-1:0] r_mem_xp [DEPTH];
  logic [NOUTPUTS-1:0] r_mem_mk [DEPTH];

  state_t              r_state;
  logic [AW:0]         r_wr_ptr;      // also the entry count
  logic [AW-1:0]       r_idx;
  logic [WW-1:0]       r_wait;
  logic                r_sof;
  logic [NINPUTS-1:0]  r_pi_out;
  logic                r_busy;
  logic                r_done;
  logic                r_fail_pulse;
  logic [AW-1:0]       r_fail_pat;
  logic [NOUTPUTS-1:0] r_fail_bits;
  logic [CNTW-1:0]     r_fail_count;
  logic                r_ff_valid;
  logic [AW-1:0]       r_ff_pat;
  logic [AW:0]         r_pat_count;

  logic                w_load_ready;
  logic                w_wr;
  logic                w_clear;
  logic [NOUTPUTS-1:0] w_mis;
  logic                w_last;
  logic [AW-1:0]       w_idx_nx;
  logic [CNTW-1:0]     w_fc_inc;

  assign w_load_ready = (r_state != S_RUN) && (r_wr_ptr < FULL);
  assign w_wr         = ld.load_valid && w_load_ready;
  // clear is only honoured outside a run and beats a simultaneous start
  assign w_clear      = clear && (r_state != S_RUN);
  assign w_mis        = (po_in ^ r_mem_xp[r_idx]) & r_mem_mk[r_idx];
  assign w_last       = ({1'b0, r_idx} == (r_wr_ptr - (AW+1)'(1)));
  assign w_idx_nx     = r_idx + AW'(1);
  assign w_fc_inc     = (r_fail_count == '1) ? r_fail_count
                                             : r_fail_count + CNTW'(1);

  // Buffer write port: one record per accepted handshake
  always_ff @(posedge clk) begin
    if (w_wr) begin
      r_mem_pi[r_wr_ptr[AW-1:0]] <= ld.load_pi;
      r_mem_xp[r_wr_ptr[AW-1:0]] <= ld.load_xpct;
      r_mem_mk[r_wr_ptr[AW-1:0]] <= ld.load_mask;
    end
  end

  // Run controller: loading, clear/start, apply/settle/strobe sequencing
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_wr_ptr     <= '0;
      r_idx        <= '0;
      r_wait       <= '0;
      r_sof        <= 1'b0;
      r_pi_out     <= '0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_fail_pulse <= 1'b0;
      r_fail_pat   <= '0;
      r_fail_bits  <= '0;
      r_fail_count <= '0;
      r_ff_valid   <= 1'b0;
      r_ff_pat     <= '0;
      r_pat_count  <= '0;
    end else begin
      r_fail_pulse <= 1'b0;

      if (w_clear)   r_wr_ptr <= '0;
      else if (w_wr) r_wr_ptr <= r_wr_ptr + (AW+1)'(1);

      case (r_state)
        S_IDLE, S_DONE: begin
          if (w_clear || start) begin
            // Both clear and start wipe the previous run's results
            r_fail_pat   <= '0;
            r_fail_bits  <= '0;
            r_fail_count <= '0;
            r_ff_valid   <= 1'b0;
            r_ff_pat     <= '0;
            r_pat_count  <= '0;
          end
          if (w_clear) begin
            r_done  <= 1'b0;
            r_state <= S_IDLE;
          end else if (start) begin
            if (r_wr_ptr == '0) begin
              r_done  <= 1'b1;
              r_busy  <= 1'b0;
              r_state <= S_DONE;
            end else begin
              r_pi_out <= r_mem_pi[0];
              r_idx    <= '0;
              r_wait   <= WAIT_INIT;
              r_sof    <= stop_on_fail;
              r_busy   <= 1'b1;
              r_done   <= 1'b0;
              r_state  <= S_RUN;
            end
          end
        end

        S_RUN: begin
          if (r_wait != '0) begin
            r_wait <= r_wait - WW'(1);
          end else begin
            r_pat_count <= r_pat_count + (AW+1)'(1);
            if (w_mis != '0) begin
              r_fail_pulse <= 1'b1;
              r_fail_pat   <= r_idx;
              r_fail_bits  <= w_mis;
              r_fail_count <= w_fc_inc;
              if (!r_ff_valid) begin
                r_ff_valid <= 1'b1;
                r_ff_pat   <= r_idx;
              end
            end
            if (w_last || (r_sof && (w_mis != '0))) begin
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
              r_state <= S_DONE;
            end else begin
              // next pattern goes out on the same edge as this strobe
              r_idx    <= w_idx_nx;
              r_pi_out <= r_mem_pi[w_idx_nx];
              r_wait   <= WAIT_INIT;
            end
          end
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign ld.load_ready      = w_load_ready;
  assign pi_out             = r_pi_out;
  assign busy               = r_busy;
  assign done               = r_done;
  assign fail_pulse         = r_fail_pulse;
  assign fail_pat           = r_fail_pat;
  assign fail_bits          = r_fail_bits;
  assign fail_count         = r_fail_count;
  assign first_fail_valid   = r_ff_valid;
  assign first_fail_pat     = r_ff_pat;
  assign pat_count          = r_pat_count;
endmodule
